cont_delay_check: RTL and testbench

CONT_DELAY_CHECK -- requirements
Module: cont_delay_check

---
 rtl/cont_delay_check.sv | 191 +++++++++++++++++++
 tb/tb_cont_delay_check.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cont_delay_check.sv
// Checks that a net follows its driver after RISE_DLY / FALL_DLY cycles (4-state, 2-bit encoded).
// Optional pass/fail statistics counters: define CONT_DELAY_CHECK_STATS_EN.
module cont_delay_check #(
  parameter int RISE_DLY = 1,
  parameter int FALL_DLY = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       drv_in,
  input  logic [1:0]       net_out,
  input  logic             chk_en,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             cancel,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] meas_dly,
  output logic [CNT_W-1:0] exp_dly,
  output logic [15:0]      pass_cnt,
  output logic [15:0]      fail_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VX = 2'b10;
  localparam logic [1:0] VZ = 2'b11;
  localparam int MIN_DLY = (RISE_DLY < FALL_DLY) ? RISE_DLY : FALL_DLY;

  function automatic logic [CNT_W-1:0] dly_for(input logic [1:0] v);
    case (v)
      V1:      return CNT_W'(RISE_DLY);
      V0:      return CNT_W'(FALL_DLY);
      default: return CNT_W'(MIN_DLY);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       drv_q, net_q;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] expc_q, expc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d, fail_q, fail_d, cancel_q, cancel_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] meas_q, meas_d, expo_q, expo_d;

  logic             drv_chg, result;
  logic [CNT_W-1:0] new_dly, cnt_inc;

  assign drv_chg = (drv_in != drv_q);
  assign new_dly = dly_for(drv_in);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    target_d = target_q;
    expc_d   = expc_q;
    cnt_d    = cnt_q;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
    cancel_d = 1'b0;
    err_d    = err_q;
    meas_d   = meas_q;
    expo_d   = expo_q;
    result   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (chk_en && drv_chg) begin
          if (net_out == drv_in) begin
            fail_d = 1'b1;
            err_d  = 2'b01;
            meas_d = '0;
            expo_d = new_dly;
          end else begin
            state_d  = S_WAIT;
            target_d = drv_in;
            expc_d   = new_dly;
            cnt_d    = '0;
          end
        end
      end
      S_WAIT: begin
        // A spurious net transition outranks the timing checks.
        if (net_out != net_q && net_out != target_q) begin
          result = 1'b1;
          fail_d = 1'b1;
          err_d  = 2'b11;
          meas_d = cnt_inc;
        end else if (net_out == target_q) begin
          result = 1'b1;
          meas_d = cnt_inc;
          if (cnt_inc == expc_q) begin
            pass_d = 1'b1;
            err_d  = 2'b00;
          end else begin
            fail_d = 1'b1;
            err_d  = 2'b01;
          end
        end else if (cnt_inc == expc_q) begin
          result = 1'b1;
          fail_d = 1'b1;
          err_d  = 2'b10;
          meas_d = expc_q;
        end

        if (result) begin
          expo_d = expc_q;
          if (chk_en && drv_chg) begin
            target_d = drv_in;
            expc_d   = new_dly;
            cnt_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (drv_in != target_q) begin
          cancel_d = 1'b1;
          target_d = drv_in;
          expc_d   = new_dly;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments; reset drives history to z/x so the first real value counts as a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      drv_q    <= VZ;
      net_q    <= VX;
      target_q <= V0;
      expc_q   <= '0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      cancel_q <= 1'b0;
      err_q    <= 2'b00;
      meas_q   <= '0;
      expo_q   <= '0;
    end else begin
      state_q  <= state_d;
      drv_q    <= drv_in;
      net_q    <= net_out;
      target_q <= target_d;
      expc_q   <= expc_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      cancel_q <= cancel_d;
      err_q    <= err_d;
      meas_q   <= meas_d;
      expo_q   <= expo_d;
    end
  end

  assign busy     = (state_q == S_WAIT);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign cancel   = cancel_q;
  assign err_code = err_q;
  assign meas_dly = meas_q;
  assign exp_dly  = expo_q;

`ifdef CONT_DELAY_CHECK_STATS_EN
  logic [15:0] pass_cnt_q, fail_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (pass_d && pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 1'b1;
      if (fail_d && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 1'b1;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`else
  assign pass_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_cont_delay_check.sv
// Scoreboard bench for cont_delay_check (RISE_DLY=1, FALL_DLY=2): expected pulses queued at stimulus time.
module tb_cont_delay_check;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VX = 2'b10;
  localparam logic [1:0] VZ = 2'b11;

  localparam int K_PASS = 0;
  localparam int K_FAIL = 1;
  localparam int K_CANCEL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  drv_in, net_out;
  logic        chk_en;
  logic        busy, pass, fail, cancel;
  logic [1:0]  err_code;
  logic [7:0]  meas_dly, exp_dly;
  logic [15:0] pass_cnt, fail_cnt;

  cont_delay_check #(.RISE_DLY(1), .FALL_DLY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .drv_in(drv_in), .net_out(net_out), .chk_en(chk_en),
    .busy(busy), .pass(pass), .fail(fail), .cancel(cancel), .err_code(err_code),
    .meas_dly(meas_dly), .exp_dly(exp_dly), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [1:0] err;
    logic [7:0] meas;
    logic [7:0] expd;
    bit         chk_meas;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mdl_pass = 0;
  int mdl_fail = 0;

  // Scoreboard consumer: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!rst && (pass || fail || cancel)) begin
      k = pass ? K_PASS : (fail ? K_FAIL : K_CANCEL);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind=%0d, expected no pulse", k);
      end else begin
        e = sb.pop_front();
        if (e.kind == K_PASS) mdl_pass++;
        if (e.kind == K_FAIL) mdl_fail++;
        if (k !== e.kind) begin
          errors++;
          $display("FAIL pulse_kind: got %0d, expected %0d", k, e.kind);
        end else if (k != K_CANCEL) begin
          checks++;
          if (err_code !== e.err) begin
            errors++;
            $display("FAIL err_code: got %b, expected %b", err_code, e.err);
          end
          checks++;
          if (exp_dly !== e.expd) begin
            errors++;
            $display("FAIL exp_dly: got %0d, expected %0d", exp_dly, e.expd);
          end
          if (e.chk_meas) begin
            checks++;
            if (meas_dly !== e.meas) begin
              errors++;
              $display("FAIL meas_dly: got %0d, expected %0d", meas_dly, e.meas);
            end
          end
        end
      end
    end
  end

  task automatic push(input int kind, input logic [1:0] err, input logic [7:0] meas,
                      input logic [7:0] expd, input bit chk_meas);
    exp_t e;
    e.kind = kind; e.err = err; e.meas = meas; e.expd = expd; e.chk_meas = chk_meas;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] d, input logic [1:0] n);
    @(negedge clk);
    drv_in  = d;
    net_out = n;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d expected pulses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; chk_en = 1'b1; drv_in = VZ; net_out = VZ;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, pass, fail, cancel} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 0000", {busy, pass, fail, cancel});
    end
    checks++;
    if ({err_code, meas_dly, exp_dly} !== 18'd0) begin
      errors++;
      $display("FAIL reset_result: got err=%b meas=%0d exp=%0d, expected 0", err_code, meas_dly, exp_dly);
    end
    checks++;
    if ({pass_cnt, fail_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d, expected 0/0", pass_cnt, fail_cnt);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // z -> 0 on the driver, net follows two cycles later.
    drive(V0, VZ);
    push(K_PASS, 2'b00, 8'd2, 8'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_wait: got %b, expected 1", busy);
    end
    drive(V0, V0);
    wait_done(10);
  endtask

  task automatic test_rise_and_x;
    drive(V1, V0);
    push(K_PASS, 2'b00, 8'd1, 8'd1, 1'b1);
    drive(V1, V1);
    wait_done(10);
    drive(VX, V1);
    push(K_PASS, 2'b00, 8'd1, 8'd1, 1'b1);
    drive(VX, VX);
    wait_done(10);
  endtask

  task automatic test_cancel;
    drive(V0, VX);
    push(K_CANCEL, 2'b00, 8'd0, 8'd0, 1'b0);
    drive(V1, VX);
    push(K_PASS, 2'b00, 8'd1, 8'd1, 1'b1);
    drive(V1, V1);
    wait_done(10);
  endtask

  task automatic test_late;
    drive(V0, V1);
    push(K_FAIL, 2'b10, 8'd2, 8'd2, 1'b1);
    wait_done(10);
    repeat (2) @(negedge clk);
    checks++;
    if ({fail, err_code, exp_dly} !== {1'b0, 2'b10, 8'd2}) begin
      errors++;
      $display("FAIL late_hold: got fail=%b err=%b exp=%0d, expected 0/10/2", fail, err_code, exp_dly);
    end
  endtask

  task automatic test_idle_early;
    drive(V1, V1);
    push(K_FAIL, 2'b01, 8'd0, 8'd1, 1'b1);
    wait_done(10);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_early_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_wrong_value;
    drive(V1, VX);
    drive(V0, VX);
    push(K_FAIL, 2'b11, 8'd1, 8'd2, 1'b0);
    drive(V0, V1);
    wait_done(10);
  endtask

  task automatic test_early;
    drive(V0, VX);
    drive(V1, VX);
    push(K_PASS, 2'b00, 8'd1, 8'd1, 1'b1);
    drive(V1, V1);
    wait_done(10);
    drive(V1, VX);
    drive(V0, VX);
    push(K_FAIL, 2'b01, 8'd1, 8'd2, 1'b1);
    drive(V0, V0);
    wait_done(10);
  endtask

  task automatic test_back_to_back;
    drive(V1, V0);
    push(K_PASS, 2'b00, 8'd1, 8'd1, 1'b1);
    drive(V0, V1);
    push(K_PASS, 2'b00, 8'd2, 8'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload_busy: got %b, expected 1", busy);
    end
    drive(V0, V0);
    wait_done(10);
  endtask

  task automatic test_chk_en;
    @(negedge clk);
    chk_en = 1'b0; drv_in = V1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL chk_en_off_busy: got %b, expected 0", busy);
    end
    drive(V1, V1);
    @(negedge clk);
    chk_en = 1'b1; drv_in = V0;
    push(K_PASS, 2'b00, 8'd2, 8'd2, 1'b1);
    @(negedge clk);
    chk_en = 1'b0;
    drive(V0, V0);
    wait_done(10);
    chk_en = 1'b1;
  endtask

  task automatic test_stats;
    int exp_pc, exp_fc;
`ifdef CONT_DELAY_CHECK_STATS_EN
    exp_pc = mdl_pass; exp_fc = mdl_fail;
`else
    exp_pc = 0; exp_fc = 0;
`endif
    @(negedge clk);
    checks++;
    if (pass_cnt !== 16'(exp_pc)) begin
      errors++;
      $display("FAIL pass_cnt: got %0d, expected %0d", pass_cnt, exp_pc);
    end
    checks++;
    if (fail_cnt !== 16'(exp_fc)) begin
      errors++;
      $display("FAIL fail_cnt: got %0d, expected %0d", fail_cnt, exp_fc);
    end
  endtask

  task automatic test_rst_mid_wait;
    drive(V1, V0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: got %b, expected 1", busy);
    end
    #2;
    rst = 1'b1; drv_in = VZ; net_out = VZ;
    mdl_pass = 0; mdl_fail = 0;
    #1;
    checks++;
    if ({busy, pass, fail, cancel} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async: got %b, expected 0000", {busy, pass, fail, cancel});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({pass_cnt, fail_cnt, err_code} !== 34'd0) begin
      errors++;
      $display("FAIL rst_clear: got pc=%0d fc=%0d err=%b, expected 0", pass_cnt, fail_cnt, err_code);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wait_done(2);
  endtask

  initial begin
    test_reset();
    test_rise_and_x();
    test_cancel();
    test_late();
    test_idle_early();
    test_wrong_value();
    test_early();
    test_back_to_back();
    test_chk_en();
    test_stats();
    test_rst_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
